// File: rtl/mandelbrot_iterator_if.sv
// rtl/mandelbrot_iterator_if.sv - pixel request/result bundle for the Mandelbrot iterator
// Optional abort line present when ITER_ABORT_EN is defined.
interface mandelbrot_iterator_if;
   logic        start;
   logic [15:0] c_re;
   logic [15:0] c_im;
   logic [7:0]  max_iter;
   logic        busy;
   logic        done;
   logic [7:0]  iteration;
   logic        ismandelbrot;
`ifdef ITER_ABORT_EN
   logic        abort;

   modport master (
      output start, c_re, c_im, max_iter, abort,
      input  busy, done, iteration, ismandelbrot
   );
   modport slave (
      input  start, c_re, c_im, max_iter, abort,
      output busy, done, iteration, ismandelbrot
   );
`else
   modport master (
      output start, c_re, c_im, max_iter,
      input  busy, done, iteration, ismandelbrot
   );
   modport slave (
      input  start, c_re, c_im, max_iter,
      output busy, done, iteration, ismandelbrot
   );
`endif
endinterface

// File: rtl/mandelbrot_iterator.sv
// rtl/mandelbrot_iterator.sv - Q4.12 escape-time iterator for one Mandelbrot pixel
// Optional feature: ITER_ABORT_EN adds an abort input that cancels a computation.
module mandelbrot_iterator (
   input logic                  clk,
   input logic                  rst,
   mandelbrot_iterator_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ITERATE, S_DONE} state_t;

   localparam logic signed [32:0] ESCAPE_LIM = 33'sh4000000;
   localparam logic signed [32:0] SAT_MAX    = 33'sd32767;
   localparam logic signed [32:0] SAT_MIN    = -33'sd32768;

   state_t             state_q, state_d;
   logic signed [15:0] c_re_q, c_re_d;
   logic signed [15:0] c_im_q, c_im_d;
   logic [7:0]         max_iter_q, max_iter_d;
   logic signed [15:0] z_re_q, z_re_d;
   logic signed [15:0] z_im_q, z_im_d;
   logic [7:0]         count_q, count_d;
   logic [7:0]         res_iter_q, res_iter_d;
   logic               res_ism_q, res_ism_d;
   logic [7:0]         iteration_q, iteration_d;
   logic               ismandelbrot_q, ismandelbrot_d;
   logic               done_q, done_d;

   logic signed [31:0] zr2, zi2, zri;
   logic signed [32:0] mag, diff, dbl, re_sum, im_sum;
   logic               escape;

   function automatic logic [15:0] sat16(input logic signed [32:0] v);
      if (v > SAT_MAX)
         return 16'h7FFF;
      else if (v < SAT_MIN)
         return 16'h8000;
      else
         return v[15:0];
   endfunction

   // Full-width arithmetic keeps every intermediate exact before saturation.
   always_comb begin
      zr2    = z_re_q * z_re_q;
      zi2    = z_im_q * z_im_q;
      zri    = z_re_q * z_im_q;
      mag    = $signed({zr2[31], zr2}) + $signed({zi2[31], zi2});
      diff   = $signed({zr2[31], zr2}) - $signed({zi2[31], zi2});
      dbl    = $signed({zri, 1'b0});
      re_sum = (diff >>> 12) + $signed({{17{c_re_q[15]}}, c_re_q});
      im_sum = (dbl >>> 12) + $signed({{17{c_im_q[15]}}, c_im_q});
      escape = (mag >= ESCAPE_LIM);
   end

   always_comb begin
      state_d        = state_q;
      c_re_d         = c_re_q;
      c_im_d         = c_im_q;
      max_iter_d     = max_iter_q;
      z_re_d         = z_re_q;
      z_im_d         = z_im_q;
      count_d        = count_q;
      res_iter_d     = res_iter_q;
      res_ism_d      = res_ism_q;
      iteration_d    = iteration_q;
      ismandelbrot_d = ismandelbrot_q;
      done_d         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               c_re_d     = bus.c_re;
               c_im_d     = bus.c_im;
               max_iter_d = bus.max_iter;
               z_re_d     = 16'sd0;
               z_im_d     = 16'sd0;
               count_d    = 8'd0;
               state_d    = S_ITERATE;
            end
         end
         S_ITERATE: begin
            if (escape) begin
               res_iter_d = count_q;
               res_ism_d  = 1'b0;
               state_d    = S_DONE;
            end else if (count_q == max_iter_q) begin
               res_iter_d = count_q;
               res_ism_d  = 1'b1;
               state_d    = S_DONE;
            end else begin
               z_re_d  = sat16(re_sum);
               z_im_d  = sat16(im_sum);
               count_d = count_q + 8'd1;
            end
         end
         S_DONE: begin
            // Results are published together with the pulse so an abort in DONE leaves them intact.
            done_d         = 1'b1;
            iteration_d    = res_iter_q;
            ismandelbrot_d = res_ism_q;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef ITER_ABORT_EN
      if (bus.abort && (state_q != S_IDLE)) begin
         state_d        = S_IDLE;
         done_d         = 1'b0;
         iteration_d    = iteration_q;
         ismandelbrot_d = ismandelbrot_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         c_re_q         <= 16'sd0;
         c_im_q         <= 16'sd0;
         max_iter_q     <= 8'd0;
         z_re_q         <= 16'sd0;
         z_im_q         <= 16'sd0;
         count_q        <= 8'd0;
         res_iter_q     <= 8'd0;
         res_ism_q      <= 1'b0;
         iteration_q    <= 8'd0;
         ismandelbrot_q <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         c_re_q         <= c_re_d;
         c_im_q         <= c_im_d;
         max_iter_q     <= max_iter_d;
         z_re_q         <= z_re_d;
         z_im_q         <= z_im_d;
         count_q        <= count_d;
         res_iter_q     <= res_iter_d;
         res_ism_q      <= res_ism_d;
         iteration_q    <= iteration_d;
         ismandelbrot_q <= ismandelbrot_d;
         done_q         <= done_d;
      end
   end

   assign bus.busy         = (state_q != S_IDLE);
   assign bus.done         = done_q;
   assign bus.iteration    = iteration_q;
   assign bus.ismandelbrot = ismandelbrot_q;

endmodule
